// File: rtl/lsu_axi_lite.sv
// Load/store unit: turns one pipeline memory request at a time into a single
// AXI4-Lite read or write, with byte-lane steering, load extension and stall.
module lsu_axi_lite #(
    parameter int          ADDR_W = 32,
    parameter int          DATA_W = 32,
    parameter logic [2:0]  PROT   = 3'b000
) (
    input  logic                  ACLK,
    input  logic                  RESET,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  stall,
    output logic [ADDR_W-1:0]     M_AXI_AWADDR,
    output logic [2:0]            M_AXI_AWPROT,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [DATA_W-1:0]     M_AXI_WDATA,
    output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    output logic [ADDR_W-1:0]     M_AXI_ARADDR,
    output logic [2:0]            M_AXI_ARPROT,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [DATA_W-1:0]     M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_WB, S_RA, S_RD, S_RESP} state_t;

    state_t              r_state, w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata, r_rdata;
    logic [STRB_W-1:0]   r_strb;
    logic [1:0]          r_size;
    logic                r_uns, r_aw_done, r_w_done, r_err;
    logic [OFF_W-1:0]    r_off;

    logic                w_accept, w_illegal, w_aw_hs, w_w_hs, w_sign, w_fill;
    logic [OFF_W-1:0]    w_off;
    logic [3:0]          w_bytes;
    logic [6:0]          w_nbits;
    logic [STRB_W-1:0]   w_strb;
    logic [DATA_W-1:0]   w_wdata, w_lane, w_ext;

    assign w_accept = req_valid && (r_state == S_IDLE);
    assign w_off    = req_addr[OFF_W-1:0];
    assign w_bytes  = 4'd1 << req_size;

    always_comb begin
        w_illegal = 1'b0;
        case (req_size)
            2'd1:    w_illegal = req_addr[0];
            2'd2:    w_illegal = |req_addr[1:0];
            2'd3:    w_illegal = (DATA_W == 32) || (|req_addr[2:0]);
            default: w_illegal = 1'b0;
        endcase
    end

    // Store data is replicated per access size so every lane the strobe selects carries it.
    always_comb begin
        w_strb  = '0;
        w_wdata = '0;
        for (int i = 0; i < STRB_W; i++) begin
            w_strb[i] = (i >= int'(w_off)) && (i < int'(w_off) + int'(w_bytes));
            w_wdata[8*i +: 8] = req_wdata[8*(i % int'(w_bytes)) +: 8];
        end
    end

    assign w_lane  = M_AXI_RDATA >> {r_off, 3'b000};
    assign w_nbits = 7'd8 << r_size;

    always_comb begin
        w_sign = 1'b0;
        case (r_size)
            2'd0:    w_sign = w_lane[7];
            2'd1:    w_sign = w_lane[15];
            2'd2:    w_sign = w_lane[31];
            default: w_sign = w_lane[DATA_W-1];
        endcase
        w_fill = !r_uns && w_sign;
        w_ext  = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_ext[i] = (i < int'(w_nbits)) ? w_lane[i] : w_fill;
        end
    end

    assign w_aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_w_hs  = M_AXI_WVALID && M_AXI_WREADY;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_illegal ? S_RESP : (req_write ? S_WR : S_RA);
            S_WR:   if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_next = S_WB;
            S_WB:   if (M_AXI_BVALID) w_next = S_RESP;
            S_RA:   if (M_AXI_ARREADY) w_next = S_RD;
            S_RD:   if (M_AXI_RVALID) w_next = S_RESP;
            S_RESP: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge RESET) begin
        if (RESET) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_strb    <= '0;
            r_size    <= '0;
            r_uns     <= 1'b0;
            r_off     <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr    <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                r_wdata   <= w_wdata;
                r_strb    <= w_strb;
                r_size    <= req_size;
                r_uns     <= req_unsigned;
                r_off     <= w_off;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
                r_err     <= w_illegal;
                r_rdata   <= '0;
            end
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
            if (r_state == S_WB && M_AXI_BVALID) r_err <= (M_AXI_BRESP != 2'b00);
            if (r_state == S_RD && M_AXI_RVALID) begin
                r_err   <= (M_AXI_RRESP != 2'b00);
                r_rdata <= (M_AXI_RRESP == 2'b00) ? w_ext : '0;
            end
        end
    end

    // READY/stall are gated by RESET so every handshake output is low while it is held.
    assign req_ready     = (r_state == S_IDLE) && !RESET;
    assign stall         = !RESET && ((r_state != S_IDLE) || req_valid);
    assign rsp_valid     = (r_state == S_RESP);
    assign rsp_rdata     = rsp_valid ? r_rdata : '0;
    assign rsp_err       = rsp_valid && r_err;
    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_AWPROT  = PROT;
    assign M_AXI_AWVALID = (r_state == S_WR) && !r_aw_done;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_strb;
    assign M_AXI_WVALID  = (r_state == S_WR) && !r_w_done;
    assign M_AXI_BREADY  = (r_state == S_WB);
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_ARPROT  = PROT;
    assign M_AXI_ARVALID = (r_state == S_RA);
    assign M_AXI_RREADY  = (r_state == S_RD);
endmodule
